// File: rtl/dot_product_unit.sv
// Dot-product engine: reads two 8-element unsigned byte vectors from a shared
// synchronous-read operand memory (A at 0-7, B at 8-15), accumulates A[i]*B[i]
// and reports an 8-bit (saturated or truncated) result plus an overflow flag.
module dot_product_unit #(
    parameter bit SAT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_compute,
    input  logic       comp_start,
    output logic [3:0] mem_addr,
    output logic       mem_rd_en,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       comp_done,
    output logic [7:0] comp_result,
    output logic       result_ovf
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        MAC  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [2:0]   idx;
    logic [18:0]  acc;
    logic [7:0]   a_reg;
    logic [15:0]  prod;
    logic [18:0]  sum;
    logic         start_ok;
    logic         last_mac;

    // Reduce the full 19-bit sum to the 8-bit result field.
    function automatic logic [7:0] clip_result(input logic [18:0] s);
        if (SAT && (s > 19'd255)) begin
            return 8'hFF;
        end
        return s[7:0];
    endfunction

    // In MAC, mem_rdata carries B[idx] and a_reg holds A[idx].
    assign prod     = {8'd0, a_reg} * {8'd0, mem_rdata};
    assign sum      = acc + {3'd0, prod};
    assign start_ok = (state == IDLE) && comp_start && mode_compute;
    assign last_mac = (state == MAC) && (idx == 3'd7) && mode_compute;

    // Memory is only driven while fetching; otherwise the controller owns it.
    assign mem_rd_en = (state == RD_A) || (state == RD_B);
    assign mem_addr  = (state == RD_A) ? {1'b0, idx} :
                       (state == RD_B) ? {1'b1, idx} : 4'd0;
    assign busy      = (state == RD_A) || (state == RD_B) || (state == MAC);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; losing mode_compute mid-fetch aborts to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = RD_A;
            RD_A: state_nxt = mode_compute ? RD_B : IDLE;
            RD_B: state_nxt = mode_compute ? MAC : IDLE;
            MAC: begin
                if (!mode_compute)      state_nxt = IDLE;
                else if (idx == 3'd7)   state_nxt = DONE;
                else                    state_nxt = RD_A;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Element index, operand latch and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= 3'd0;
            acc   <= 19'd0;
            a_reg <= 8'd0;
        end else if (start_ok) begin
            idx <= 3'd0;
            acc <= 19'd0;
        end else if (mode_compute) begin
            if (state == RD_B) begin
                a_reg <= mem_rdata;
            end
            if (state == MAC) begin
                acc <= sum;
                if (idx != 3'd7) begin
                    idx <= idx + 3'd1;
                end
            end
        end
    end

    // Result registers and completion pulse, all loaded by the final MAC edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_done   <= 1'b0;
            comp_result <= 8'd0;
            result_ovf  <= 1'b0;
        end else begin
            comp_done <= last_mac;
            if (last_mac) begin
                comp_result <= clip_result(sum);
                result_ovf  <= (sum > 19'd255);
            end
        end
    end

endmodule

// File: tb/tb_dot_product_unit.sv
// Directed bench for dot_product_unit: one saturating and one truncating
// instance share stimulus and the operand memory contents.
module tb_dot_product_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       mode_compute;
    logic       comp_start;
    logic [3:0] addr_s, addr_t;
    logic       en_s, en_t;
    logic [7:0] rdata_s, rdata_t;
    logic       busy_s, busy_t;
    logic       done_s, done_t;
    logic [7:0] res_s, res_t;
    logic       ovf_s, ovf_t;

    logic [7:0] mem [16];

    dot_product_unit #(.SAT(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .mode_compute(mode_compute), .comp_start(comp_start),
        .mem_addr(addr_s), .mem_rd_en(en_s), .mem_rdata(rdata_s), .busy(busy_s),
        .comp_done(done_s), .comp_result(res_s), .result_ovf(ovf_s)
    );

    dot_product_unit #(.SAT(1'b0)) dut_trn (
        .clk(clk), .rst_n(rst_n), .mode_compute(mode_compute), .comp_start(comp_start),
        .mem_addr(addr_t), .mem_rd_en(en_t), .mem_rdata(rdata_t), .busy(busy_t),
        .comp_done(done_t), .comp_result(res_t), .result_ovf(ovf_t)
    );

    // Synchronous-read operand memory model.
    always @(posedge clk) begin
        if (en_s) rdata_s <= mem[addr_s];
        if (en_t) rdata_t <= mem[addr_t];
    end

    typedef struct {
        logic [63:0] a;       // element i at [8*i +: 8]
        logic [63:0] b;
        int          res_sat;
        int          res_trn;
        int          ovf;
    } vec_t;

    vec_t vecs[7];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_mem(input logic [63:0] a, input logic [63:0] b);
        for (int i = 0; i < 8; i++) begin
            mem[i]     = a[8*i +: 8];
            mem[8 + i] = b[8*i +: 8];
        end
    endtask

    // Full operation on vector vi; optionally re-pulses comp_start at cycle repulse_at.
    task automatic run_op(input int vi, input int repulse_at);
        int done_at, pulses_s, pulses_t, busy_n, addr_bad;
        logic [3:0] exp_a;
        logic       exp_en;
        done_at = -1; pulses_s = 0; pulses_t = 0; busy_n = 0; addr_bad = 0;
        load_mem(vecs[vi].a, vecs[vi].b);
        mode_compute = 1'b1;
        comp_start   = 1'b1;
        @(negedge clk);
        comp_start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy_s) busy_n++;
            if (done_s) begin
                pulses_s++;
                if (done_at < 0) done_at = k;
            end
            if (done_t) pulses_t++;
            exp_a = 4'd0; exp_en = 1'b0;
            if (k < 24 && (k % 3) == 0) begin exp_a = 4'(k / 3);     exp_en = 1'b1; end
            if (k < 24 && (k % 3) == 1) begin exp_a = 4'(8 + k / 3); exp_en = 1'b1; end
            if (addr_s !== exp_a || en_s !== exp_en || addr_t !== exp_a || en_t !== exp_en)
                addr_bad++;
            comp_start = (k == repulse_at);
            @(negedge clk);
        end
        comp_start = 1'b0;
        check($sformatf("v%0d_done_cycle", vi), done_at, 24);
        check($sformatf("v%0d_done_pulses_sat", vi), pulses_s, 1);
        check($sformatf("v%0d_done_pulses_trn", vi), pulses_t, 1);
        check($sformatf("v%0d_busy_cycles", vi), busy_n, 24);
        check($sformatf("v%0d_addr_seq_errors", vi), addr_bad, 0);
        check($sformatf("v%0d_result_sat", vi), int'(res_s), vecs[vi].res_sat);
        check($sformatf("v%0d_result_trn", vi), int'(res_t), vecs[vi].res_trn);
        check($sformatf("v%0d_ovf_sat", vi), int'(ovf_s), vecs[vi].ovf);
        check($sformatf("v%0d_ovf_trn", vi), int'(ovf_t), vecs[vi].ovf);
    endtask

    initial begin
        int pulses, busy_n, en_n;
        vecs[0] = '{64'h0101010101010101, 64'h0807060504030201, 36, 36, 0};
        vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 255, 8, 1};
        vecs[2] = '{64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF, 0, 0, 0};
        vecs[3] = '{64'h0807060504030201, 64'h0807060504030201, 204, 204, 0};
        vecs[4] = '{64'h1010101010101010, 64'h0202020202020202, 255, 0, 1};
        vecs[5] = '{64'h0A0A0A0A0A0A0A0A, 64'h0303030303030303, 240, 240, 0};
        vecs[6] = '{64'h00000000000000FF, 64'h0000000000000001, 255, 255, 0};

        rst_n = 1'b0; mode_compute = 1'b0; comp_start = 1'b0;
        load_mem(64'd0, 64'd0);
        #12;
        check("reset_result", int'(res_s), 0);
        check("reset_ovf", int'(ovf_s), 0);
        check("reset_done", int'(done_s), 0);
        check("reset_busy", int'(busy_s), 0);
        check("reset_rd_en", int'(en_s), 0);
        check("reset_addr", int'(addr_s), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            run_op(v, -1);
        end

        // Abort: vector 3 leaves 204; then drop mode_compute 10 cycles into vector 0.
        run_op(3, -1);
        load_mem(vecs[0].a, vecs[0].b);
        mode_compute = 1'b1; comp_start = 1'b1;
        @(negedge clk);
        comp_start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_s || done_t) pulses++;
            if (k == 10) check("abort_busy_before", int'(busy_s), 1);
            if (k == 11) begin
                check("abort_busy_after", int'(busy_s), 0);
                check("abort_rd_en_after", int'(en_s), 0);
            end
            if (k == 10) mode_compute = 1'b0;
            @(negedge clk);
        end
        check("abort_no_done", pulses, 0);
        check("abort_result_kept_sat", int'(res_s), 204);
        check("abort_result_kept_trn", int'(res_t), 204);
        check("abort_ovf_kept", int'(ovf_s), 0);
        run_op(0, -1);

        // Start re-pulsed mid-operation is ignored.
        run_op(5, 5);

        // Start with mode_compute low does nothing.
        mode_compute = 1'b0; comp_start = 1'b1;
        @(negedge clk);
        comp_start = 1'b0;
        pulses = 0; busy_n = 0; en_n = 0;
        for (int k = 0; k < 30; k++) begin
            if (done_s || done_t) pulses++;
            if (busy_s || busy_t) busy_n++;
            if (en_s || en_t) en_n++;
            @(negedge clk);
        end
        check("nomode_done", pulses, 0);
        check("nomode_busy", busy_n, 0);
        check("nomode_rd_en", en_n, 0);
        check("nomode_result_kept", int'(res_s), 240);

        // Asynchronous reset at cycle 12 of an operation.
        load_mem(vecs[1].a, vecs[1].b);
        mode_compute = 1'b1; comp_start = 1'b1;
        @(negedge clk);
        comp_start = 1'b0;
        for (int k = 0; k < 12; k++) @(negedge clk);
        check("prereset_busy", int'(busy_s), 1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_result_sat", int'(res_s), 0);
        check("areset_result_trn", int'(res_t), 0);
        check("areset_ovf", int'(ovf_s), 0);
        check("areset_busy", int'(busy_s), 0);
        check("areset_rd_en", int'(en_s), 0);
        check("areset_addr", int'(addr_s), 0);
        check("areset_done", int'(done_s), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0; busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_s || done_t) pulses++;
            if (busy_s || busy_t) busy_n++;
            @(negedge clk);
        end
        check("postreset_no_done", pulses, 0);
        check("postreset_no_busy", busy_n, 0);
        run_op(4, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dot_product_unit.md
DOT_PRODUCT_UNIT -- requirements
Module: dot_product_unit

Interface
REQ-001 SHALL have parameter: SAT, 1, 1 = saturate comp_result to 255 on overflow; 0 = truncate to acc[7:0].
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: mode_compute  in  1  compute-phase enable from controller; memory belongs to this block only while high.
REQ-005 SHALL have port: comp_start  in  1  one-cycle start pulse from controller.
REQ-006 SHALL have port: mem_addr  out  4  operand memory read address; 0-7 = vector A, 8-15 = vector B.
REQ-007 SHALL have port: mem_rd_en  out  1  read strobe to operand memory.
REQ-008 SHALL have port: mem_rdata  in  8  read data; valid the cycle after mem_addr/mem_rd_en are presented (synchronous read).
REQ-009 SHALL have port: busy  out  1  high from the cycle after an accepted start until comp_done is asserted.
REQ-010 SHALL have port: comp_done  out  1  one-cycle completion pulse, registered.
REQ-011 SHALL have port: comp_result  out  8  dot-product result, registered, valid while comp_done is high and held until the next accepted start.
REQ-012 SHALL have port: result_ovf  out  1  high when the full sum exceeded 255; same timing as comp_result.

Function
REQ-013 SHALL compute sum over i=0..7 of A[i]*B[i], all operands unsigned 8-bit, products 16-bit, in a 19-bit accumulator (max 520200, no internal wrap).
REQ-014 SHALL implement states IDLE, RD_A, RD_B, MAC, DONE with a 3-bit element index idx.
REQ-015 IDLE: a start is accepted when comp_start=1 and mode_compute=1 at an edge; the accepting edge clears acc and idx and enters RD_A.
REQ-016 RD_A: mem_addr={0,idx}, mem_rd_en=1; next state RD_B.
REQ-017 RD_B: mem_addr={1,idx}, mem_rd_en=1; the edge leaving RD_B latches mem_rdata (A[idx]) into a_reg; next state MAC.
REQ-018 MAC: the edge leaving MAC adds a_reg*mem_rdata (B[idx]) to acc; if idx=7, go to DONE, else increment idx and go to RD_A.
REQ-019 DONE: comp_done=1 for exactly one cycle; next state IDLE.
REQ-020 Timing: RD_A, RD_B and MAC take one cycle each, 3 cycles per element. comp_done SHALL be high in the cycle following the 24th edge after the accepting edge.
REQ-021 The last MAC edge SHALL load comp_result (min(sum,255) if SAT=1, else sum[7:0]) and result_ovf=(sum>255).
REQ-022 Outside RD_A/RD_B: mem_addr=0 and mem_rd_en=0, so the block never reads while the controller is writing.
REQ-023 comp_start with mode_compute=0 SHALL be ignored; comp_start while not IDLE SHALL be ignored.
REQ-024 If mode_compute=0 at an edge in RD_A, RD_B or MAC: abort to IDLE, no comp_done, comp_result/result_ovf unchanged, busy=0 next cycle.
REQ-025 Start and abort are judged by the value of mode_compute at that edge; abort takes priority in any non-IDLE state.
REQ-026 Once mode_compute falls in DONE, the comp_done pulse SHALL still complete.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, idx=0, acc=0, a_reg=0, comp_result=0, result_ovf=0, comp_done=0, busy=0, mem_rd_en=0, mem_addr=0.
REQ-028 Reset mid-operation SHALL discard the partial sum with no comp_done; operation resumes on the first edge with rst_n high.

Verification
REQ-029 A=all 1, B=1..8, SAT=1; start+mode pulse -> comp_done high exactly 24 edges after accept, comp_result=36, result_ovf=0, busy high 24 cycles.
REQ-030 A=B=all 255 -> SAT=1: comp_result=255, result_ovf=1; SAT=0: comp_result=8 (520200 mod 256), result_ovf=1.
REQ-031 A=all 0, B=all 255 -> comp_result=0, result_ovf=0; mem_addr sequence 0,8,_,1,9,_,...,7,15 with mem_rd_en matching.
REQ-032 mode_compute dropped 10 cycles after accept -> no comp_done, IDLE, prior comp_result retained; a new start then yields the correct result.
REQ-033 comp_start re-pulsed at cycle 5 of an operation -> ignored, single comp_done at the original time; comp_start with mode_compute=0 -> no activity.
REQ-034 rst_n asserted at cycle 12 mid-operation -> all outputs 0 asynchronously, no comp_done after release.
